// File: rtl/user_module_bit_stream_monitor_pkg.sv
// ============================================================================
// Module   : user_module_bit_stream_monitor_pkg
// Brief    : Width constants and view-select encoding for the bit stream monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package user_module_bit_stream_monitor_pkg;

    localparam int TOT_W  = 8;
    localparam int DIR_W  = 4;
    localparam int RUN_W  = 7;
    localparam int HIST_W = 8;

    typedef enum logic [1:0] {
        VIEW_TOT  = 2'd0,
        VIEW_HIST = 2'd1,
        VIEW_DIR  = 2'd2,
        VIEW_RUN  = 2'd3
    } view_e;

endpackage

`default_nettype wire

// File: rtl/user_module_bit_stream_monitor_bsm_edge_detect.sv
// ============================================================================
// Module   : bsm_edge_detect
// Brief    : Holds the previous sample and flags rising/falling transitions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsm_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic en,
    input  logic clr,
    output logic prev,
    output logic prev_nxt,
    output logic sample,
    output logic rise,
    output logic fall
);

    logic r_prev;

    // clr discards the concurrent sample, so it also suppresses the strobes.
    assign sample = rst_n & en & ~clr;
    assign rise   = sample &  din & ~r_prev;
    assign fall   = sample & ~din &  r_prev;
    assign prev   = r_prev;

    always_comb begin
        prev_nxt = r_prev;
        if (!rst_n || clr) begin
            prev_nxt = 1'b0;
        end else if (en) begin
            prev_nxt = din;
        end
    end

    always_ff @(posedge clk) begin
        r_prev <= prev_nxt;
    end

endmodule

`default_nettype wire

// File: rtl/user_module_bit_stream_monitor.sv
// ============================================================================
// Module   : user_module_bit_stream_monitor
// Brief    : Counts edges, run length and history of a sampled 1-bit stream;
//            presents one of four registered 8-bit views on io_out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module user_module_bit_stream_monitor
    import user_module_bit_stream_monitor_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic  w_clk;
    logic  w_rst_n;
    logic  w_din;
    logic  w_en;
    logic  w_clr;
    logic  w_hold;
    view_e w_sel;

    assign w_clk   = io_in[0];
    assign w_rst_n = io_in[1];
    assign w_din   = io_in[2];
    assign w_en    = io_in[3];
    assign w_clr   = io_in[4];
    assign w_sel   = view_e'(io_in[6:5]);
    assign w_hold  = io_in[7];

    logic w_prev;
    logic w_prev_nxt;
    logic w_sample;
    logic w_rise;
    logic w_fall;

    bsm_edge_detect u_edge (
        .clk      (w_clk),
        .rst_n    (w_rst_n),
        .din      (w_din),
        .en       (w_en),
        .clr      (w_clr),
        .prev     (w_prev),
        .prev_nxt (w_prev_nxt),
        .sample   (w_sample),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    logic [TOT_W-1:0]  r_tot,  w_tot_nxt;
    logic [DIR_W-1:0]  r_rise, w_rise_nxt;
    logic [DIR_W-1:0]  r_fall, w_fall_nxt;
    logic [RUN_W-1:0]  r_run,  w_run_nxt;
    logic [HIST_W-1:0] r_hist, w_hist_nxt;
    logic [7:0]        r_out,  w_view;

    always_comb begin
        w_tot_nxt  = r_tot;
        w_rise_nxt = r_rise;
        w_fall_nxt = r_fall;
        w_run_nxt  = r_run;
        w_hist_nxt = r_hist;
        if (w_clr) begin
            w_tot_nxt  = '0;
            w_rise_nxt = '0;
            w_fall_nxt = '0;
            w_run_nxt  = '0;
            w_hist_nxt = '0;
        end else if (w_sample) begin
            w_hist_nxt = {r_hist[HIST_W-2:0], w_din};
            w_run_nxt  = !w_din ? '0 : ((r_run == '1) ? r_run : r_run + 1'b1);
            // Direction counters saturate; the total counter wraps.
            if (w_rise) begin
                w_tot_nxt  = r_tot + 1'b1;
                w_rise_nxt = (r_rise == '1) ? r_rise : r_rise + 1'b1;
            end
            if (w_fall) begin
                w_tot_nxt  = r_tot + 1'b1;
                w_fall_nxt = (r_fall == '1) ? r_fall : r_fall + 1'b1;
            end
        end
    end

    // The view is built from next-state values so io_out tracks din with one edge of latency.
    always_comb begin
        w_view = '0;
        case (w_sel)
            VIEW_TOT:  w_view = w_tot_nxt;
            VIEW_HIST: w_view = w_hist_nxt;
            VIEW_DIR:  w_view = {w_rise_nxt, w_fall_nxt};
            VIEW_RUN:  w_view = {w_run_nxt, w_prev_nxt};
            default:   w_view = '0;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_tot  <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_run  <= '0;
            r_hist <= '0;
            r_out  <= '0;
        end else begin
            r_tot  <= w_tot_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_run  <= w_run_nxt;
            r_hist <= w_hist_nxt;
            if (!w_hold) begin
                r_out <= w_view;
            end
        end
    end

    assign io_out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_user_module_bit_stream_monitor.sv
// ============================================================================
// Module   : tb_user_module_bit_stream_monitor
// Brief    : Directed vector table plus long-run sequences for the stream monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_user_module_bit_stream_monitor;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       din   = 1'b0;
    logic       en    = 1'b0;
    logic       clr   = 1'b0;
    logic       hold  = 1'b0;
    logic [1:0] sel   = 2'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_cmp = 0;
    int n_err = 0;

    assign io_in = {hold, sel, clr, en, din, rst_n, clk};

    always #5 clk = ~clk;

    user_module_bit_stream_monitor dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    typedef struct {
        logic       rst_n;
        logic       din;
        logic       en;
        logic       clr;
        logic       hold;
        logic [1:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic d, input logic e, input logic c,
                                input logic h, input logic [1:0] s, input logic [7:0] x);
        vec_t v;
        v.rst_n = r; v.din = d; v.en = e; v.clr = c; v.hold = h; v.sel = s; v.exp = x;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic r, input logic d, input logic e, input logic c,
                        input logic h, input logic [1:0] s);
        @(negedge clk);
        rst_n = r; din = d; en = e; clr = c; hold = h; sel = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        n_cmp++;
        if (io_out !== exp) begin
            n_err++;
            $display("FAIL %s: io_out=0x%02h expected 0x%02h", name, io_out, exp);
        end
    endtask

    initial begin
        // rst din en clr hold sel exp
        // Reset with sampling active, every view reads zero.
        add(0, 1, 1, 0, 0, 2'd0, 8'h00);
        add(0, 1, 1, 0, 0, 2'd1, 8'h00);
        add(0, 1, 1, 0, 0, 2'd2, 8'h00);
        add(0, 1, 1, 0, 0, 2'd3, 8'h00);
        add(1, 1, 1, 0, 0, 2'd0, 8'h01);   // leading 1 counts as a rise
        add(0, 0, 0, 0, 1, 2'd0, 8'h00);   // hold ignored in reset
        // Edge counting: 1,0,1,1,0
        add(1, 1, 1, 0, 0, 2'd0, 8'h01);
        add(1, 0, 1, 0, 0, 2'd0, 8'h02);
        add(1, 1, 1, 0, 0, 2'd0, 8'h03);
        add(1, 1, 1, 0, 0, 2'd0, 8'h03);
        add(1, 0, 1, 0, 0, 2'd0, 8'h04);
        add(1, 0, 0, 0, 0, 2'd2, 8'h22);
        // History/run: 1,0,1,1
        add(0, 0, 0, 0, 0, 2'd1, 8'h00);
        add(1, 1, 1, 0, 0, 2'd1, 8'h01);
        add(1, 0, 1, 0, 0, 2'd1, 8'h02);
        add(1, 1, 1, 0, 0, 2'd1, 8'h05);
        add(1, 1, 1, 0, 0, 2'd1, 8'h0B);
        add(1, 0, 0, 0, 0, 2'd3, 8'h05);
        add(1, 0, 1, 0, 0, 2'd3, 8'h00);   // tot=4, hist=0x16
        // hold: three 1 samples frozen, then released
        add(1, 0, 0, 0, 0, 2'd0, 8'h04);
        add(1, 1, 1, 0, 1, 2'd0, 8'h04);
        add(1, 1, 1, 0, 1, 2'd0, 8'h04);
        add(1, 1, 1, 0, 1, 2'd3, 8'h04);
        add(1, 0, 0, 0, 0, 2'd3, 8'h07);   // run=3, last=1
        add(1, 0, 0, 0, 0, 2'd0, 8'h05);
        // en=0 with din toggling: no change
        add(1, 1, 0, 0, 0, 2'd0, 8'h05);
        add(1, 0, 0, 0, 0, 2'd0, 8'h05);
        add(1, 1, 0, 0, 0, 2'd1, 8'hB7);
        add(1, 0, 0, 0, 0, 2'd2, 8'h32);
        // clr beats en; sample discarded
        add(1, 1, 1, 1, 0, 2'd0, 8'h00);
        add(1, 1, 1, 1, 0, 2'd1, 8'h00);
        add(1, 1, 1, 1, 0, 2'd2, 8'h00);
        add(1, 1, 1, 1, 0, 2'd3, 8'h00);
        add(1, 1, 1, 0, 0, 2'd0, 8'h01);
        // clr under hold keeps io_out, then shows the cleared state
        add(1, 1, 1, 1, 1, 2'd0, 8'h01);
        add(1, 0, 0, 0, 0, 2'd0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].din, vecs[i].en, vecs[i].clr, vecs[i].hold, vecs[i].sel);
            check($sformatf("vec[%0d]", i), vecs[i].exp);
        end

        // 40 alternating samples: tot=40, rise/fall saturate at 15
        step(0, 0, 0, 0, 0, 2'd0);
        for (int i = 0; i < 40; i++) step(1, (i % 2 == 0), 1, 0, 0, 2'd0);
        check("alt40_tot", 8'h28);
        step(1, 0, 0, 0, 0, 2'd2);
        check("alt40_dir", 8'hFF);
        step(1, 0, 0, 0, 0, 2'd3);
        check("alt40_run", 8'h00);

        // 256 alternating samples: tot wraps to 0
        step(0, 0, 0, 0, 0, 2'd0);
        for (int i = 0; i < 256; i++) step(1, (i % 2 == 0), 1, 0, 0, 2'd0);
        check("alt256_tot", 8'h00);
        step(1, 0, 0, 0, 0, 2'd2);
        check("alt256_dir", 8'hFF);

        // Run counter saturates at 127
        step(0, 0, 0, 0, 0, 2'd3);
        for (int i = 0; i < 126; i++) step(1, 1, 1, 0, 0, 2'd3);
        check("run126", 8'hFD);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 2'd3);
        check("run_sat", 8'hFF);
        step(1, 1, 0, 0, 0, 2'd0);
        check("run_tot", 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/user_module_bit_stream_monitor.md
Name: user_module_bit_stream_monitor

Overview:
- Downstream consumer for a combinational logic-cell user module.
- Samples that module's 1-bit function output as a serial stream and counts rising and falling edges.
- Keeps a sample history and the current run of ones, and presents one of four 8-bit views on io_out.
- Same 8-in/8-out Tiny Tapeout user-module shell as its neighbours: io_in[0] is the clock, io_in[1] is the reset.

Parameters:
- None overridable.
- Fixed constants: TOT_W = 8 (total-edge counter), DIR_W = 4 (rise/fall counters), RUN_W = 7 (ones-run counter), HIST_W = 8 (sample history).

Ports:
- io_in[0]  input  1  clk; all state updates on its rising edge.
- io_in[1]  input  1  rst_n; synchronous, active-low; sampled on clk.
- io_in[2]  input  1  din; bit stream from the upstream logic function output.
- io_in[3]  input  1  en; sample enable; din is taken only when en=1.
- io_in[4]  input  1  clr; synchronous clear of monitor state.
- io_in[6:5]  input  2  sel; output view select.
- io_in[7]  input  1  hold; freezes io_out.
- io_out[7:0]  output  8  registered view selected by sel.

Behaviour:
- Priority per clk edge: rst_n=0 > clr=1 > en=1 > idle.
- Reset (rst_n=0): prev, tot, rise, fall, run, hist and io_out_q all 0. hold is ignored during reset.
- clr=1 (rst_n=1): prev, tot, rise, fall, run and hist go to 0; the din sample in that cycle is discarded even if en=1.
  - io_out_q loads the view of the cleared state, unless hold=1.
- Sample cycle (en=1, no clr); s = din:
  - hist <= {hist[6:0], s}.
  - prev <= s.
  - Rising edge if s=1 and prev=0: rise += 1 (saturates at 15), tot += 1 (wraps 255 -> 0).
  - Falling edge if s=0 and prev=1: fall += 1 (saturates at 15), tot += 1 (wraps).
  - run <= s ? min(run+1, 127) : 0.
  - The first sample after reset/clr is compared against prev=0, so a leading 1 counts as a rise.
- Idle (en=0): all monitor state holds; din is ignored.
- Output register io_out_q:
  - Updates every edge where hold=0, from the NEXT-state values, so a sample on edge N is visible on io_out immediately after edge N (1-cycle latency from din).
  - hold=1 keeps io_out_q unchanged while monitor state still updates.
  - sel change takes effect at the next edge with hold=0.
- Views:
  - sel=0: tot[7:0].
  - sel=1: hist[7:0] (bit0 = newest sample).
  - sel=2: {rise[3:0], fall[3:0]}.
  - sel=3: {run[6:0], last sample} where last sample = prev.
- No combinational path from io_in to io_out; io_out = io_out_q.
- Reset mid-stream: all history lost; the next en sample is treated as the first.

Decomposition:
- Shared package: the width constants above and a 2-bit view enum: VIEW_TOT=0, VIEW_HIST=1, VIEW_DIR=2, VIEW_RUN=3.
- One natural sub-module: bsm_edge_detect (prev register, rise/fall strobes, en/clr handling).
- Counters, history, view mux and output register stay in the top.
- Target size is about 150-250 lines of RTL.

Test Plan:
- Reset: rst_n=0 for 2 clks with en=1, din=1, all sel values -> io_out=0x00 each cycle; first en sample after release (din=1, sel=0) -> io_out=0x01.
- Edge counting: after reset, en=1, din=1,0,1,1,0, sel=0 -> io_out=0x04 after 5th edge; then sel=2 with one idle clk -> 0x22.
- History/run: after reset, din=1,0,1,1 with en=1, sel=1 -> 0x0B; sel=3 with one idle clk -> 0x05 (run=2, last=1); next sample 0 -> 0x00.
- Saturation/wrap: alternating 1,0 for 40 samples -> sel=0 0x28, sel=2 0xFF; 256 alternating samples from reset -> sel=0 0x00, sel=2 0xFF.
- hold and en: hold=1, 3 samples din=1 -> io_out unchanged; hold=0 next edge -> reflects all 3 samples. en=0 with din toggling -> no state change.
- clr precedence: clr=1 with en=1, din=1 after prior activity -> all views 0x00; next sample din=1 -> sel=0 0x01 (rise vs prev=0).
